lsu: RTL

Load/store unit sitting directly upstream of the word-addressed data memory (combinational read, posedge write, no byte enables). Accepts one RV32I load or store per request from the execute stage, enforces alignment, and performs byte/halfword extraction with sign/zero extension on loads. Sub-word stores are done as a read-modify-write sequence. A registered result and a one-cycle `done` pulse return to the core, which stalls while `ready` is low.

---
 rtl/lsu.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lsu.sv
// RV32I load/store unit in front of a word-addressed data memory.
// Sub-word stores use read-modify-write; one-cycle done pulse on completion.
module lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] load_data_o,
    output logic [31:0] dm_addr_o,
    output logic        dm_mem_write_o,
    output logic [31:0] dm_write_data_o,
    input  logic [31:0] dm_read_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        ERR
    } state_e;

    state_e      state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] load_data_q;

    logic        legal;
    logic        misal;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;
    logic [31:0] merged;

    always_comb begin
        legal = 1'b0;
        misal = 1'b0;
        case (funct3_i)
            3'b000: legal = 1'b1;
            3'b001: begin
                legal = 1'b1;
                misal = addr_i[0];
            end
            3'b010: begin
                legal = 1'b1;
                misal = |addr_i[1:0];
            end
            3'b100: legal = ~we_i;
            3'b101: begin
                legal = ~we_i;
                misal = addr_i[0];
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        byte_v = dm_read_data_i[{addr_q[1:0], 3'b000} +: 8];
        half_v = addr_q[1] ? dm_read_data_i[31:16] : dm_read_data_i[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_ext = {{16{half_v[15]}}, half_v};
            3'b100:  load_ext = {24'b0, byte_v};
            3'b101:  load_ext = {16'b0, half_v};
            default: load_ext = dm_read_data_i;
        endcase
    end

    // Merge the store data into the word captured during READ.
    always_comb begin
        merged = rdata_q;
        case (f3_q)
            3'b000:  merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            3'b001:  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'b0;
            wdata_q     <= 32'b0;
            rdata_q     <= 32'b0;
            load_data_q <= 32'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        f3_q    <= funct3_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        if (!legal || misal)
                            state_q <= ERR;
                        else if (we_i && funct3_i == 3'b010)
                            state_q <= WRITE;
                        else
                            state_q <= READ;
                    end
                end
                READ: begin
                    rdata_q <= dm_read_data_i;
                    if (!we_q) begin
                        load_data_q <= load_ext;
                        state_q     <= RESP;
                    end else begin
                        state_q <= WRITE;
                    end
                end
                WRITE:   state_q <= RESP;
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o         = (state_q == IDLE);
    assign done_o          = (state_q == RESP) || (state_q == ERR);
    assign err_o           = (state_q == ERR);
    assign load_data_o     = load_data_q;
    assign dm_addr_o       = {addr_q[31:2], 2'b00};
    assign dm_mem_write_o  = (state_q == WRITE);
    assign dm_write_data_o = merged;

endmodule
